// File: rtl/mrr_sfo_fft_norm_apply.sv
// mrr_sfo_fft_norm_apply: per-bin arithmetic right shift and saturation of
// secondary-FFT samples, delivered through a 2-stage valid/ready pipeline.
module mrr_sfo_fft_norm_apply #(
  parameter int IN_WIDTH    = 32,
  parameter int OUT_WIDTH   = 16,
  parameter int IDX_WIDTH   = 10,
  parameter int SEC_WIDTH   = 6,
  parameter int SHIFT_WIDTH = 5
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clear,
  input  logic [IDX_WIDTH-1:0]   setting_primary_fft_len_mask,
  input  logic [SEC_WIDTH-1:0]   setting_secondary_fft_len_mask,
  input  logic [IN_WIDTH-1:0]    in_i,
  input  logic [IN_WIDTH-1:0]    in_q,
  input  logic                   in_valid,
  output logic                   in_ready,
  output logic [IDX_WIDTH-1:0]   norm_idx_next,
  input  logic [SHIFT_WIDTH-1:0] norm_shift,
  output logic [OUT_WIDTH-1:0]   out_i,
  output logic [OUT_WIDTH-1:0]   out_q,
  output logic [SHIFT_WIDTH-1:0] out_shift,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   out_last
);
  localparam logic signed [IN_WIDTH-1:0] MAX_V = IN_WIDTH'(2 ** (OUT_WIDTH - 1) - 1);
  localparam logic signed [IN_WIDTH-1:0] MIN_V = IN_WIDTH'(-(2 ** (OUT_WIDTH - 1)));
  localparam logic [SHIFT_WIDTH:0] OW = (SHIFT_WIDTH + 1)'(OUT_WIDTH);

  function automatic logic [OUT_WIDTH-1:0] sat(input logic signed [IN_WIDTH-1:0] v);
    return v > MAX_V ? MAX_V[OUT_WIDTH-1:0] : v < MIN_V ? MIN_V[OUT_WIDTH-1:0] : v[OUT_WIDTH-1:0];
  endfunction

  logic [IDX_WIDTH-1:0] bin_q, bin_d;
  logic [SEC_WIDTH-1:0] frame_q, frame_d;
  logic s1_valid_q, s1_valid_d, s1_last_q, s1_last_d;
  logic signed [IN_WIDTH-1:0] s1_i_q, s1_i_d, s1_q_q, s1_q_d, v_i, v_q;
  logic [OUT_WIDTH-1:0] out_i_q, out_i_d, out_q_q, out_q_d;
  logic [SHIFT_WIDTH-1:0] out_shift_q, out_shift_d, rshift;
  logic [SHIFT_WIDTH:0] shift_sum;
  logic out_valid_q, out_valid_d, out_last_q, out_last_d;
  logic s1_adv, in_fire, s2_ld, bin_wrap, frame_wrap;

  always_comb begin
    s1_adv      = !out_valid_q | out_ready;
    in_ready    = !s1_valid_q | s1_adv;
    in_fire     = in_valid & in_ready;
    bin_wrap    = bin_q == setting_primary_fft_len_mask;
    frame_wrap  = frame_q == setting_secondary_fft_len_mask;
    bin_d       = in_fire ? (bin_wrap ? '0 : bin_q + 1'b1) : bin_q;
    frame_d     = (in_fire & bin_wrap) ? (frame_wrap ? '0 : frame_q + 1'b1) : frame_q;
    s1_valid_d  = in_fire | (s1_valid_q & !s1_adv);
    s1_i_d      = in_fire ? in_i : s1_i_q;
    s1_q_d      = in_fire ? in_q : s1_q_q;
    s1_last_d   = in_fire ? bin_wrap & frame_wrap : s1_last_q;
    // norm_shift belongs to the bin sitting in S1 (norm_idx_next - 1)
    shift_sum   = {1'b0, norm_shift} + (SHIFT_WIDTH + 1)'(2);
    rshift      = shift_sum > OW ? SHIFT_WIDTH'(shift_sum - OW) : '0;
    v_i         = s1_i_q >>> rshift;
    v_q         = s1_q_q >>> rshift;
    s2_ld       = s1_adv & s1_valid_q;
    out_valid_d = s1_adv ? s1_valid_q : out_valid_q;
    out_i_d     = s2_ld ? sat(v_i) : out_i_q;
    out_q_d     = s2_ld ? sat(v_q) : out_q_q;
    out_shift_d = s2_ld ? rshift : out_shift_q;
    out_last_d  = s2_ld ? s1_last_q : out_last_q;
  end

  always_ff @(posedge clk) begin
    if (rst | clear) begin
      bin_q       <= '0;
      frame_q     <= '0;
      s1_valid_q  <= 1'b0;
      s1_i_q      <= '0;
      s1_q_q      <= '0;
      s1_last_q   <= 1'b0;
      out_valid_q <= 1'b0;
      out_i_q     <= '0;
      out_q_q     <= '0;
      out_shift_q <= '0;
      out_last_q  <= 1'b0;
    end else begin
      bin_q       <= bin_d;
      frame_q     <= frame_d;
      s1_valid_q  <= s1_valid_d;
      s1_i_q      <= s1_i_d;
      s1_q_q      <= s1_q_d;
      s1_last_q   <= s1_last_d;
      out_valid_q <= out_valid_d;
      out_i_q     <= out_i_d;
      out_q_q     <= out_q_d;
      out_shift_q <= out_shift_d;
      out_last_q  <= out_last_d;
    end
  end

  assign norm_idx_next = bin_q;
  assign out_i         = out_i_q;
  assign out_q         = out_q_q;
  assign out_shift     = out_shift_q;
  assign out_valid     = out_valid_q;
  assign out_last      = out_last_q;
endmodule
